// File: rtl/rv64g_l1_vlsu_miss_sequencer.sv
// Serializes VLSU per-lane misses into one-at-a-time line Acquires, merging lanes that share a 64B line,
// then hands back replay/error lane masks once every line has been refilled, denied or timed out.
module rv64g_l1_vlsu_miss_sequencer #(
    parameter int NUM_LANES = 8,
    parameter int ADDR_W    = 64,
    parameter int TIMEOUT   = 1023
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    miss_valid_i,
    output logic                    miss_ready_o,
    input  logic [NUM_LANES-1:0]    lane_miss_i,
    input  logic [NUM_LANES*ADDR_W-1:0] lane_addr_i,
    input  logic [NUM_LANES-1:0]    lane_store_i,
    output logic                    acq_valid_o,
    input  logic                    acq_ready_i,
    output logic [ADDR_W-7:0]       acq_line_o,
    output logic [1:0]              acq_grow_o,
    input  logic                    refill_done_i,
    input  logic                    refill_denied_i,
    output logic                    replay_valid_o,
    input  logic                    replay_ready_i,
    output logic [NUM_LANES-1:0]    replay_mask_o,
    output logic [NUM_LANES-1:0]    err_mask_o,
    output logic                    busy_o
);

    localparam int LINE_W = ADDR_W - 6;
    localparam int CNT_W  = $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ISSUE  = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_REPLAY = 2'd3;

    logic [1:0]            state;
    logic [NUM_LANES-1:0]  pend;
    logic [NUM_LANES-1:0]  grp;
    logic [NUM_LANES-1:0]  ok;
    logic [NUM_LANES-1:0]  err;
    logic [NUM_LANES-1:0]  store;
    logic [LINE_W-1:0]     line [NUM_LANES];
    logic [CNT_W-1:0]      cnt;

    logic                  lead_found;
    logic [LINE_W-1:0]     lead_line;
    logic [NUM_LANES-1:0]  sel_grp;
    logic                  sel_store;
    logic                  timeout_hit;
    logic [5:0]            unused_offsets;

    // Leader is the lowest pending lane; every pending lane on its line rides along in the same Acquire.
    always_comb begin
        lead_found = 1'b0;
        lead_line  = '0;
        sel_grp    = '0;
        sel_store  = 1'b0;
        for (int l = 0; l < NUM_LANES; l++) begin
            if (pend[l] && !lead_found) begin
                lead_found = 1'b1;
                lead_line  = line[l];
            end
        end
        for (int l = 0; l < NUM_LANES; l++) begin
            if (pend[l] && (line[l] == lead_line)) begin
                sel_grp[l] = 1'b1;
                sel_store  = sel_store | store[l];
            end
        end
    end

    always_comb begin
        unused_offsets = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            unused_offsets = unused_offsets ^ lane_addr_i[l*ADDR_W +: 6];
        end
    end

    // The counter is checked before incrementing, so WAIT lasts exactly TIMEOUT cycles when no refill arrives.
    assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));

    assign miss_ready_o   = (state == S_IDLE);
    assign acq_valid_o    = (state == S_ISSUE);
    assign acq_line_o     = acq_valid_o ? lead_line : '0;
    assign acq_grow_o     = {1'b0, acq_valid_o & sel_store};
    assign replay_valid_o = (state == S_REPLAY);
    assign replay_mask_o  = replay_valid_o ? ok  : '0;
    assign err_mask_o     = replay_valid_o ? err : '0;
    assign busy_o         = (state != S_IDLE);

    always_ff @(posedge clk_i) begin
        if (miss_valid_i && miss_ready_o) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                line[l] <= lane_addr_i[l*ADDR_W + 6 +: LINE_W];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state <= S_IDLE;
            pend  <= '0;
            grp   <= '0;
            ok    <= '0;
            err   <= '0;
            store <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (miss_valid_i) begin
                        pend  <= lane_miss_i;
                        store <= lane_store_i;
                        ok    <= '0;
                        err   <= '0;
                        state <= (|lane_miss_i) ? S_ISSUE : S_REPLAY;
                    end
                end
                S_ISSUE: begin
                    if (acq_ready_i) begin
                        grp   <= sel_grp;
                        pend  <= pend & ~sel_grp;
                        cnt   <= '0;
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    cnt <= cnt + CNT_W'(1);
                    // A refill landing on the timeout cycle still counts as a refill.
                    if (refill_done_i) begin
                        if (refill_denied_i) begin
                            err <= err | grp;
                        end else begin
                            ok <= ok | grp;
                        end
                        state <= (|pend) ? S_ISSUE : S_REPLAY;
                    end else if (timeout_hit) begin
                        err   <= err | grp;
                        state <= (|pend) ? S_ISSUE : S_REPLAY;
                    end
                end
                default: begin
                    if (replay_ready_i) begin
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule
